// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the main-memory arbiter: state/owner encodings and block geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;
    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;
    localparam int WORDS_PER_BLK = 8;
    localparam int MEM_LAT       = 4;
    localparam int OFF_W         = 4;
    localparam int WIDX_W        = $clog2(WORDS_PER_BLK);
    localparam int BLK_W         = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IC   = 2'd1,
        DC   = 2'd2
    } owner_t;

    // Block base of a byte address (drops the 16-byte block offset).
    function automatic logic [BLK_W-1:0] blk_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFF_W];
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache request, fill return and main-memory signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are level-held by the caches until their done pulse.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              ic_miss;
    logic [ADDR_W-1:0] ic_miss_addr;
    logic              dc_miss;
    logic [ADDR_W-1:0] dc_miss_addr;
    logic              dc_wr_req;
    logic [ADDR_W-1:0] dc_wr_addr;
    logic [DATA_W-1:0] dc_wr_data;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] fill_data;
    logic [WIDX_W-1:0] fill_word;
    logic              ic_fill_we;
    logic              dc_fill_we;
    logic              ic_fill_done;
    logic              dc_fill_done;
    logic              dc_wr_done;
    logic              busy;

    // Arbiter side.
    modport master (
        input  ic_miss, ic_miss_addr, dc_miss, dc_miss_addr,
        input  dc_wr_req, dc_wr_addr, dc_wr_data, mem_rdata, mem_rvalid,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
        output ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_done, busy
    );

    // Cache and memory side.
    modport slave (
        output ic_miss, ic_miss_addr, dc_miss, dc_miss_addr,
        output dc_wr_req, dc_wr_addr, dc_wr_data, mem_rdata, mem_rvalid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
        input  ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_done, busy
    );
endinterface

// File: rtl/mem_arbiter_blk_word_cnt.sv
// Word index counter within a cache block, with synchronous clear and last-word flag.
// Latency: count updates one cycle after inc; last is a decode of the current count.
// Backpressure: none; counts only when inc is high, clear has priority.
module blk_word_cnt
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [WIDX_W-1:0] cnt,
    output logic              last
);
    // Clear wins over increment; wraps naturally at block end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + WIDX_W'(1);
        end
    end

    assign last = (cnt == WIDX_W'(WORDS_PER_BLK - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: grants one cache at a time, issues a block of reads or one store.
// Latency: fill = 13 cycles from request to IDLE (done at +12); store = mem write at +1.
// Backpressure: requests wait while busy; no preemption, fixed priority dc_miss > dc_wr_req > ic_miss.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              grant_fill;
    logic              issuing;
    logic              active;
    logic              ret_fire;
    logic              fill_last;
    logic [WIDX_W-1:0] issue_cnt, ret_cnt;
    logic              issue_last, ret_last;

    assign issuing   = (state_q == ISSUE);
    assign active    = issuing || (state_q == DRAIN);
    // Returns outside a fill (stale after reset, or during a store) are dropped here.
    assign ret_fire  = active && bus.mem_rvalid;
    assign fill_last = ret_fire && ret_last;

    blk_word_cnt u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant_fill),
        .inc   (issuing),
        .cnt   (issue_cnt),
        .last  (issue_last)
    );

    blk_word_cnt u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant_fill),
        .inc   (ret_fire),
        .cnt   (ret_cnt),
        .last  (ret_last)
    );

    // Next-state, owner and block-base selection; D side outranks I side.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        blk_d      = blk_q;
        grant_fill = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.dc_miss) begin
                    state_d    = ISSUE;
                    owner_d    = DC;
                    blk_d      = blk_of(bus.dc_miss_addr);
                    grant_fill = 1'b1;
                end else if (bus.dc_wr_req) begin
                    state_d = WRITE;
                end else if (bus.ic_miss) begin
                    state_d    = ISSUE;
                    owner_d    = IC;
                    blk_d      = blk_of(bus.ic_miss_addr);
                    grant_fill = 1'b1;
                end
            end
            WRITE: state_d = IDLE;
            ISSUE: begin
                if (fill_last) begin
                    state_d = IDLE;
                    owner_d = NONE;
                end else if (issue_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fill_last) begin
                    state_d = IDLE;
                    owner_d = NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= NONE;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            blk_q   <= blk_d;
        end
    end

    // Memory command: block reads while issuing, the held store while writing.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (issuing) begin
            bus.mem_addr = {blk_q, issue_cnt, 1'b0};
        end else if (state_q == WRITE) begin
            bus.mem_addr  = bus.dc_wr_addr;
            bus.mem_wdata = bus.dc_wr_data;
        end
    end

    assign bus.mem_en       = issuing || (state_q == WRITE);
    assign bus.mem_wr       = (state_q == WRITE);
    assign bus.dc_wr_done   = (state_q == WRITE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.fill_data    = ret_fire ? bus.mem_rdata : '0;
    assign bus.fill_word    = ret_fire ? ret_cnt : '0;
    assign bus.ic_fill_we   = ret_fire && (owner_q == IC);
    assign bus.dc_fill_we   = ret_fire && (owner_q == DC);
    assign bus.ic_fill_done = fill_last && (owner_q == IC);
    assign bus.dc_fill_done = fill_last && (owner_q == DC);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table-driven IC fill, hand-written corner sequences, random fills/stores.
// Latency: memory responder returns reads MEM_LAT cycles after issue.
// Backpressure: requesters hold until done and drop the following cycle.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory responder and observers ----------------
    typedef struct { int due; logic [15:0] data; } rd_t;
    rd_t         rq[$];
    logic [15:0] wmem [int];     // contents written by the DUT
    logic [15:0] ref_mem [int];  // contents the stimulus says memory should hold
    bit          inject_rv;
    int          wr_cyc;
    int          rd_log_cyc[$];
    logic [15:0] rd_log_addr[$];
    logic [15:0] ic_line [8];
    logic [15:0] dc_line [8];
    int          ic_we_total;
    int          dc_we_total;

    function automatic logic [15:0] init_word(input int i);
        return 16'((i * 40503) ^ (i >> 3) ^ 23130);
    endfunction
    function automatic logic [15:0] mem_rd(input int i);
        return wmem.exists(i) ? wmem[i] : init_word(i);
    endfunction
    function automatic logic [15:0] ref_rd(input int i);
        return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
    endfunction

    always @(negedge clk) begin
        if (bus.mem_en && !bus.mem_wr) begin
            rq.push_back('{cyc + MEM_LAT, mem_rd(int'(bus.mem_addr[15:1]))});
            rd_log_cyc.push_back(cyc);
            rd_log_addr.push_back(bus.mem_addr);
        end
        if (bus.mem_en && bus.mem_wr) begin
            wmem[int'(bus.mem_addr[15:1])] = bus.mem_wdata;
            wr_cyc = cyc;
        end
        if (bus.ic_fill_we) begin ic_line[bus.fill_word] = bus.fill_data; ic_we_total++; end
        if (bus.dc_fill_we) begin dc_line[bus.fill_word] = bus.fill_data; dc_we_total++; end
    end

    always @(posedge clk) begin
        #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            if (rq[0].due == cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rq[0].data;
            end
            void'(rq.pop_front());
        end
        if (inject_rv) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 16'($urandom);
        end
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [58:0] outs();
        return {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_data, bus.fill_word,
                bus.ic_fill_we, bus.dc_fill_we, bus.ic_fill_done, bus.dc_fill_done, bus.dc_wr_done, bus.busy};
    endfunction

    // Raise a block fill, wait for done, compare the captured line against the model memory.
    task automatic fill(input bit dc, input logic [15:0] a, output int done_cyc);
        int c0;
        bit got;
        string nm;
        logic [127:0] act, exp;
        got = 1'b0;
        done_cyc = -1;
        nm = dc ? "dc" : "ic";
        @(posedge clk); #1;
        c0 = dc ? dc_we_total : ic_we_total;
        if (dc) begin bus.dc_miss = 1'b1; bus.dc_miss_addr = a; end
        else    begin bus.ic_miss = 1'b1; bus.ic_miss_addr = a; end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (dc ? bus.dc_fill_done : bus.ic_fill_done) begin got = 1'b1; done_cyc = cyc; break; end
        end
        #1;
        for (int k = 0; k < 8; k++) begin
            act[k*16 +: 16] = dc ? dc_line[k] : ic_line[k];
            exp[k*16 +: 16] = ref_rd(int'(a[15:4]) * 8 + k);
        end
        chk({nm, "_fill_done_seen"}, 128'(got), 128'(1));
        chk({nm, "_fill_we_count"}, 128'((dc ? dc_we_total : ic_we_total) - c0), 128'(8));
        chk($sformatf("%s_fill_line_%h", nm, a), act, exp);
        @(posedge clk); #1;
        if (dc) bus.dc_miss = 1'b0; else bus.ic_miss = 1'b0;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        bit got;
        got = 1'b0;
        ref_mem[int'(a[15:1])] = d;
        @(posedge clk); #1;
        bus.dc_wr_req = 1'b1; bus.dc_wr_addr = a; bus.dc_wr_data = d;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.dc_wr_done) begin got = 1'b1; break; end
        end
        #1;
        chk("store_done_seen", 128'(got), 128'(1));
        chk("store_mem_word", 128'(mem_rd(int'(a[15:1]))), 128'(d));
        @(posedge clk); #1;
        bus.dc_wr_req = 1'b0;
    endtask

    // ---------------- table for the single IC fill ----------------
    typedef struct {
        logic        ic_miss;
        logic [15:0] ic_addr;
        logic        mem_en, mem_wr;
        logic [15:0] mem_addr;
        logic        ic_we, dc_we;
        logic [2:0]  fill_word;
        logic        ic_done, dc_done, busy;
    } vec_t;
    vec_t tbl [14];

    initial begin : wdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0, d1, d2, base, op;
        logic [15:0] a, b, d;

        for (int c = 0; c < 14; c++) begin
            tbl[c].ic_miss   = (c <= 12);
            tbl[c].ic_addr   = 16'h1234;
            tbl[c].mem_en    = (c >= 1 && c <= 8);
            tbl[c].mem_wr    = 1'b0;
            tbl[c].mem_addr  = tbl[c].mem_en ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0;
            tbl[c].ic_we     = (c >= 5 && c <= 12);
            tbl[c].dc_we     = 1'b0;
            tbl[c].fill_word = tbl[c].ic_we ? 3'(c - 5) : 3'd0;
            tbl[c].ic_done   = (c == 12);
            tbl[c].dc_done   = 1'b0;
            tbl[c].busy      = (c >= 1 && c <= 12);
        end

        rst_n = 1'b0;
        bus.ic_miss = 0; bus.ic_miss_addr = 0; bus.dc_miss = 0; bus.dc_miss_addr = 0;
        bus.dc_wr_req = 0; bus.dc_wr_addr = 0; bus.dc_wr_data = 0;
        inject_rv = 1'b0;
        wr_cyc = -1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 128'(outs()), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // IC fill at 0x1234, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            bus.ic_miss = tbl[i].ic_miss; bus.ic_miss_addr = tbl[i].ic_addr;
            @(negedge clk);
            chk($sformatf("ic_fill_row%0d", i),
                128'({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.ic_fill_we, bus.dc_fill_we,
                      bus.fill_word, bus.ic_fill_done, bus.dc_fill_done, bus.busy}),
                128'({tbl[i].mem_en, tbl[i].mem_wr, tbl[i].mem_addr, tbl[i].ic_we, tbl[i].dc_we,
                      tbl[i].fill_word, tbl[i].ic_done, tbl[i].dc_done, tbl[i].busy}));
            if (tbl[i].ic_we)
                chk($sformatf("ic_fill_data_row%0d", i), 128'(bus.fill_data),
                    128'(ref_rd(int'(16'h1230 >> 1) + int'(tbl[i].fill_word))));
        end

        // Simultaneous DC and IC misses: DC first, IC grant sampled at cycle 13.
        @(negedge clk);
        t0 = cyc + 1;
        base = rd_log_cyc.size();
        fork
            fill(1'b1, 16'h4A26, d1);
            fill(1'b0, 16'h7F08, d2);
        join
        chk("both_dc_done_cycle", 128'(d1 - t0), 128'(12));
        chk("both_ic_done_cycle", 128'(d2 - t0), 128'(25));
        chk("both_first_read", 128'({rd_log_cyc[base] - t0, rd_log_addr[base]}), 128'({32'd1, 16'h4A20}));
        chk("both_ic_first_read", 128'({rd_log_cyc[base+8] - t0, rd_log_addr[base+8]}), 128'({32'd14, 16'h7F00}));

        // Single store 0x0040 <= 0xBEEF.
        ref_mem[int'(16'h0040 >> 1)] = 16'hBEEF;
        @(posedge clk); #1;
        bus.dc_wr_req = 1'b1; bus.dc_wr_addr = 16'h0040; bus.dc_wr_data = 16'hBEEF;
        @(negedge clk);
        chk("store_c0", 128'({bus.mem_en, bus.busy}), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("store_c1", 128'({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.dc_wr_done, bus.busy}),
            128'({1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1, 1'b1}));
        @(posedge clk); #1;
        bus.dc_wr_req = 1'b0;
        @(negedge clk);
        chk("store_c2", 128'({bus.mem_en, bus.busy, bus.dc_wr_done}), 128'(0));

        // Store raised during an IC fill waits for the fill to finish.
        fork
            fill(1'b0, 16'h2000, d1);
            begin
                repeat (3) @(posedge clk);
                store(16'h3456, 16'hCAFE);
            end
        join
        chk("store_after_fill_cycle", 128'(wr_cyc - d1), 128'(2));

        // Reset in the middle of a DC fill, then stale returns, then a clean IC fill.
        @(posedge clk); #1;
        bus.dc_miss = 1'b1; bus.dc_miss_addr = 16'h5550;
        repeat (7) @(posedge clk); #1;
        chk("pre_reset_busy", 128'({bus.busy, bus.mem_en}), 128'(3));
        rst_n = 1'b0;
        bus.dc_miss = 1'b0;
        #1;
        chk("async_reset_outputs", 128'(outs()), 128'(0));
        inject_rv = 1'b1;
        for (int c = 8; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 9) rst_n = 1'b1;
            @(negedge clk);
            chk($sformatf("stale_rvalid_c%0d", c),
                128'({bus.ic_fill_we, bus.dc_fill_we, bus.ic_fill_done, bus.dc_fill_done, bus.busy, bus.mem_en}),
                128'(0));
        end
        inject_rv = 1'b0;
        repeat (2) @(posedge clk);
        fill(1'b0, 16'h0910, d1);

        // Random back-to-back fills and stores against the model memory.
        for (int it = 0; it < 50; it++) begin
            op = int'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            d  = 16'($urandom);
            case (op)
                0: fill(1'b0, a, d1);
                1: fill(1'b1, a, d1);
                2: begin
                    store({a[15:1], 1'b0}, d);
                    fill(1'b1, a, d1);
                end
                default: begin
                    fork
                        fill(1'b1, a, d1);
                        fill(1'b0, b, d2);
                    join
                    chk($sformatf("rand_order_%0d", it), 128'(d2 - d1), 128'(13));
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
